// File: rtl/iterative_rotate_right.sv
// Iterative rotator: restores a barrel-shifted word one bit per clock (right by default,
// left when in_dir is set) behind valid/ready handshakes on both sides.
module iterative_rotate_right #(
    parameter int WIDTH = 4,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [WIDTH-1:0] shreg_r, shreg_nxt_s;
    logic [AW-1:0]    count_r, count_nxt_s;
    logic             dir_r, dir_nxt_s;
    logic             out_valid_r, out_valid_nxt_s;
    logic [WIDTH-1:0] out_data_r, out_data_nxt_s;
    logic [AW-1:0]    amt_mod_s;
    logic [WIDTH-1:0] step_s;

    function automatic logic [WIDTH-1:0] rot_right1(input logic [WIDTH-1:0] x);
        return {x[0], x[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rot_left1(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    // Reduce the requested amount modulo WIDTH; one subtraction suffices since 2^AW < 2*WIDTH.
    always_comb begin
        if ({1'b0, in_amt} >= (AW+1)'(WIDTH)) begin
            amt_mod_s = in_amt - AW'(WIDTH);
        end else begin
            amt_mod_s = in_amt;
        end
    end

    // One rotation step in the direction latched at accept.
    always_comb begin
        if (dir_r) begin
            step_s = rot_left1(shreg_r);
        end else begin
            step_s = rot_right1(shreg_r);
        end
    end

    // Next-state and datapath control; the result register is loaded on entry to DONE.
    always_comb begin
        state_nxt_s     = state_r;
        shreg_nxt_s     = shreg_r;
        count_nxt_s     = count_r;
        dir_nxt_s       = dir_r;
        out_valid_nxt_s = out_valid_r;
        out_data_nxt_s  = out_data_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    shreg_nxt_s = in_data;
                    count_nxt_s = amt_mod_s;
                    dir_nxt_s   = in_dir;
                    if (amt_mod_s == AW'(0)) begin
                        state_nxt_s     = DONE;
                        out_valid_nxt_s = 1'b1;
                        out_data_nxt_s  = in_data;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                shreg_nxt_s = step_s;
                count_nxt_s = count_r - AW'(1);
                if (count_r == AW'(1)) begin
                    state_nxt_s     = DONE;
                    out_valid_nxt_s = 1'b1;
                    out_data_nxt_s  = step_s;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt_s     = IDLE;
                    out_valid_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                out_valid_nxt_s = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset discards any word in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            shreg_r     <= '0;
            count_r     <= '0;
            dir_r       <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            state_r     <= state_nxt_s;
            shreg_r     <= shreg_nxt_s;
            count_r     <= count_nxt_s;
            dir_r       <= dir_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            out_data_r  <= out_data_nxt_s;
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

endmodule

// File: tb/tb_iterative_rotate_right.sv
// Self-checking bench for iterative_rotate_right against a bit-index rotation model.
module tb_iterative_rotate_right;

    localparam int W  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [AW-1:0] in_amt;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    iterative_rotate_right #(.WIDTH(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: output bit i of a right rotate by s is input bit (i+s) mod W.
    function automatic logic [W-1:0] model_rot(input logic [W-1:0] x, input int s, input bit left);
        logic [W-1:0] y;
        y = '0;
        for (int i = 0; i < W; i++) begin
            if (left) y[(i + s) % W] = x[i];
            else      y[i] = x[(i + s) % W];
        end
        return y;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction with out_ready high: accept, wait for result, handshake.
    task automatic xfer(input logic [W-1:0] d, input int a, input bit dr, input string tag,
                        output logic [W-1:0] res);
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_ready_to"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = AW'(a);
        in_dir   = dr;
        tick();
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_amt   = AW'($urandom);
        in_dir   = 1'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(a));
        res = out_data;
        check({tag, "_data"}, 32'(out_data), 32'(model_rot(d, a, dr)));
        tick();
        check({tag, "_idle"}, {30'd0, busy, out_valid}, 32'd0);
    endtask

    logic [W-1:0] r, r2, b;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] wd;
    int           wa, sent, got, n;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_amt    = '0;
        in_dir    = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_vals", {28'd0, out_valid, out_data}, 32'd0);
        check("rst_ready", {30'd0, in_ready, busy}, 32'd2);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst", {26'd0, in_ready, busy, out_valid, out_data[2:0]}, 32'h20);

        // Directed inverse check and amount-zero pass-through.
        xfer(4'b1011, 1, 1'b0, "t1", r);
        check("t1_literal", 32'(r), 32'hD);
        xfer(4'hA, 0, 1'b0, "t2", r);
        check("t2_literal", 32'(r), 32'hA);

        // Round trip against a rotate-left barrel shifter for every word and amount.
        for (int a = 0; a < 16; a++) begin
            for (int s = 0; s < W; s++) begin
                b = model_rot(W'(a), s, 1'b1);
                xfer(b, s, 1'b0, "rt_r", r);
                check("rt_inverse", 32'(r), 32'(a));
                xfer(r, s, 1'b1, "rt_l", r2);
                check("rt_forward", 32'(r2), 32'(b));
            end
        end

        // Random single transactions in both directions.
        for (int k = 0; k < 20; k++) begin
            xfer(W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom), "rnd", r);
        end

        // Back-pressure with a second word waiting upstream.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h6;
        in_amt    = 2'd3;
        in_dir    = 1'b0;
        tick();
        in_data = 4'h9;
        in_amt  = 2'd2;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_lat", 32'(n), 32'd3);
        for (int c = 0; c < 5; c++) begin
            check("bp_hold", {26'd0, out_valid, in_ready, out_data}, 32'h2C);
            tick();
        end
        check("bp_hold_end", {26'd0, out_valid, in_ready, out_data}, 32'h2C);
        out_ready = 1'b1;
        tick();
        check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
        tick();
        check("bp_accept9", {30'd0, busy, in_ready}, 32'd2);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check("bp_9_lat", 32'(n), 32'd2);
        check("bp_9_data", 32'(out_data), 32'(model_rot(4'h9, 2, 1'b0)));
        tick();

        // Reset after the first shift edge discards the word.
        in_valid = 1'b1;
        in_data  = 4'h8;
        in_amt   = 2'd3;
        in_dir   = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst", {26'd0, out_valid, in_ready, busy, out_data[2:0]}, 32'h10);
        check("mid_rst_d3", 32'(out_data[3]), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_rst_idle", {30'd0, out_valid, busy}, 32'd0);
        xfer(4'h8, 3, 1'b0, "after_rst", r);
        check("after_rst_lit", 32'(r), 32'h1);

        // Streaming with out_ready tied high: results in order, none lost or duplicated.
        out_ready = 1'b1;
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("st_extra", 32'd1, 32'd0);
                end else begin
                    check("st_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
                got++;
            end
            if (in_ready && sent < 8) begin
                wd       = W'($urandom);
                wa       = int'($urandom_range(0, W - 1));
                in_valid = 1'b1;
                in_data  = wd;
                in_amt   = AW'(wa);
                in_dir   = 1'b0;
                exp_q.push_back(model_rot(wd, wa, 1'b0));
                sent++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        in_valid = 1'b0;
        check("st_count", 32'(got), 32'd8);
        check("st_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
